trig_arbiter: RTL

Round-robin arbiter and sequencer that shares one multi-cycle fixed-point cosine unit (start/done handshake, operand `x`, integer-width `M`, result) between `NREQ` requesters in the pipelined processor. It accepts one request at a time, issues the start pulse, waits for done, and returns the result to the granted requester. The cosine unit itself stays unmodified; this block owns all of its inputs.

---
 rtl/trig_arbiter_if.sv | 32 +++
 rtl/trig_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/trig_arbiter_if.sv
// Request/response bus of trig_arbiter plus its connection to the shared cosine unit.
interface trig_arbiter_if #(
  parameter int NBITS = 16,
  parameter int NREQ  = 4,
  parameter int MW    = 5
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*NBITS-1:0] req_x;
  logic [NREQ*MW-1:0]    req_m;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [NBITS-1:0]      rsp_result;
  logic                  rsp_error;
  logic                  cos_start;
  logic [NBITS-1:0]      cos_x;
  logic [MW-1:0]         cos_m;
  logic                  cos_done;
  logic [NBITS-1:0]      cos_result;
  logic                  cos_flush;

  modport slave (
    input  req_valid, req_x, req_m, cos_done, cos_result,
    output req_ready, rsp_valid, rsp_result, rsp_error,
           cos_start, cos_x, cos_m, cos_flush
  );

  modport master (
    output req_valid, req_x, req_m, cos_done, cos_result,
    input  req_ready, rsp_valid, rsp_result, rsp_error,
           cos_start, cos_x, cos_m, cos_flush
  );
endinterface

// File: rtl/trig_arbiter.sv
// Round-robin sequencer sharing one multi-cycle cosine unit among NREQ requesters.
// Optional watchdog (flush + error response) enabled by defining TRIG_ARB_TIMEOUT_EN.
module trig_arbiter #(
  parameter int NBITS   = 16,
  parameter int NREQ    = 4,
  parameter int MW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic         Clock,
  input  logic         ResetN,
  trig_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("trig_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GW-1:0]    r_last;
  logic [GW-1:0]    r_gnt;
  logic [GW-1:0]    w_gnt;
  logic             w_gnt_vld;
  logic [NBITS-1:0] r_cos_x;
  logic [MW-1:0]    r_cos_m;
  logic [NBITS-1:0] r_result;
  logic [NREQ-1:0]  w_ready;
  logic [NREQ-1:0]  w_rsp_vld;
  logic             w_start;
  logic             w_expire;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return GW'(s);
  endfunction

  // Search begins just after the last served requester, so it is visited last.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_gnt_vld && bus.req_valid[rr_idx(r_last, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = rr_idx(r_last, k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_rsp_vld   = '0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt    = S_ISSUE;
          w_ready[w_gnt] = ResetN;
        end
      end
      S_ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.cos_done || w_expire) w_state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        w_rsp_vld[r_gnt] = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state  <= S_IDLE;
      r_last   <= GW'(NREQ - 1);
      r_gnt    <= '0;
      r_cos_x  <= '0;
      r_cos_m  <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_gnt_vld) begin
        r_gnt   <= w_gnt;
        r_cos_x <= bus.req_x[int'(w_gnt)*NBITS +: NBITS];
        r_cos_m <= bus.req_m[int'(w_gnt)*MW +: MW];
      end
      // A done coinciding with watchdog expiry still returns the real result.
      if (r_state == S_WAIT && bus.cos_done)
        r_result <= bus.cos_result;
      else if (w_expire)
        r_result <= '0;
      if (r_state == S_RESPOND)
        r_last <= r_gnt;
    end
  end

`ifdef TRIG_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] r_cnt;
  logic          r_error;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_cnt   <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_WAIT && !w_expire)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_WAIT && bus.cos_done)
        r_error <= 1'b0;
      else if (w_expire)
        r_error <= 1'b1;
    end
  end

  assign w_expire      = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT));
  assign bus.cos_flush = w_expire;
  assign bus.rsp_error = r_error;
`else
  assign w_expire      = 1'b0;
  assign bus.cos_flush = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  assign bus.req_ready  = w_ready;
  assign bus.rsp_valid  = w_rsp_vld;
  assign bus.rsp_result = r_result;
  assign bus.cos_start  = w_start;
  assign bus.cos_x      = r_cos_x;
  assign bus.cos_m      = r_cos_m;
endmodule
